pif_xi_init: RTL and testbench
==============================

# pif_xi_init

Initiator side of the XI register bus. It converts a framed byte stream from the host-link front end (I2C or UART slave) into XI transactions: registered write strobes, address, write data, read sub-address and read-finished. It also samples the responder's `XO` readback after a fixed pipeline latency and returns each sample as a byte to the front end. It sits between the link deserialiser and every XI responder, which are OR-combined onto `XO`.

## Interface
Parameters:
- `A_W`, 4: width of `XI_PRWA`.
- `SUBA_W`, 4: width of `XI_PRdSubA`.
- `DATA_W`, 6: width of `XI_PD`.
- `RD_LAT`, 5: number of `xclk` edges from a stable `XI_PRdSubA`/`XI_PRWA` until `XO` is valid.

Ports:
- `xclk` in 1: sole clock.
- `sys_rst` in 1: reset, synchronous, active-high.
- `rx_start` in 1: frame start pulse; the next `rx_valid` byte is the header.
- `rx_valid` in 1: `rx_data` valid for one cycle.
- `rx_data` in 8: incoming byte.
- `rx_stop` in 1: frame end pulse.
- `tx_req` in 1: front end requests one readback byte.
- `tx_valid` out 1: one-cycle pulse; `tx_data` holds the readback byte.
- `tx_data` out 8: readback byte.
- `busy` out 1: read sample in flight.
- `XI_PWr` out 1: single-cycle write strobe.
- `XI_PRWA` out A_W: register address.
- `XI_PRdFinished` out 1: single-cycle pulse at the end of a read frame.
- `XI_PRdSubA` out SUBA_W: read sub-address.
- `XI_PD` out DATA_W: write data.
- `XO` in 8: responder readback bus.

## Operation
States: `IDLE`, `HDR`, `WR`, `RD`, `RD_WAIT`.
- **IDLE to HDR:** on `rx_start`.
- **HDR, header byte:** on `rx_valid`, load `XI_PRWA <= rx_data[A_W-1:0]` and clear `XI_PRdSubA` to 0. Then go to `RD` if `rx_data[7]` is 1, or to `WR` if it is 0.
- **WR:**
  - Each `rx_valid`: `XI_PD <= rx_data[DATA_W-1:0]` and `XI_PWr` pulses for 1 cycle. Both appear in the same cycle. Upper data bits are discarded.
  - `rx_stop` returns to `IDLE`. No `XI_PRdFinished` pulse.
- **RD:**
  - `tx_req` loads the wait counter with `RD_LAT`, sets `busy`, and enters `RD_WAIT`.
  - `rx_valid` bytes are ignored.
  - `rx_stop` pulses `XI_PRdFinished` for 1 cycle and returns to `IDLE`.
- **RD_WAIT:**
  - The counter decrements each cycle. At 0: `tx_data <= XO`, `tx_valid` pulses, `busy` clears, and `XI_PRdSubA` advances (see Configuration). Then return to `RD`.
  - `tx_req` during `RD_WAIT` is dropped.
- **Sub-address arithmetic:** modulo 2^SUBA_W; 2^SUBA_W−1 wraps to 0.
- **Boundaries:**
  - `rx_start` in any state aborts the current frame and goes to `HDR`. If the aborted frame was a read, `XI_PRdFinished` still pulses in that cycle.
  - `rx_stop` in `RD_WAIT` completes the pending sample first, then pulses `XI_PRdFinished` in the cycle after `tx_valid`.
  - `rx_stop` in the same cycle as `rx_valid` in `WR`: the write is issued and the state goes to `IDLE`.
  - `rx_stop` in `HDR` or `IDLE`: no effect beyond going to `IDLE`.
  - `sys_rst` mid-transaction: immediate return to `IDLE`. The in-flight sample is lost and no pulses are emitted.

## Timing
- **Reset values:** all outputs are 0, the state is `IDLE`, and the counter is 0.
- **All outputs are registered.**
- **Write latency:** `XI_PWr` asserts on the edge after the `rx_valid` cycle, i.e. 1 cycle.
- **Read latency:** the cycle after `tx_req`, `busy` goes to 1. `tx_valid` asserts `RD_LAT+1` cycles after `tx_req`. The next `tx_req` is accepted the cycle after `tx_valid`.
- **Address stability:** `XI_PRWA` is stable for the whole frame. `XI_PRdSubA` changes only on the `tx_valid` edge, which guarantees `RD_LAT` stable cycles before the next sample.
- **Throughput:** back-to-back `rx_valid` in `WR` gives one `XI_PWr` per cycle.

## Configuration
- **`PIF_XI_RD_AUTOINC_EN` defined:** `XI_PRdSubA` increments after each sample, wrapping as above.
- **Undefined:** `XI_PRdSubA` holds 0 for the whole frame, so every sample returns sub-address 0. The increment adder is not built.

## Structure
- **Shared defs package:**
  - `TXA`, `TXSubA`, `I2C_DATA_BITS` widths.
  - State encoding constants.
  - Header R/W bit position (bit 7).
  - Default `RD_LAT`.
- **Sub-module `pif_xi_rdwait`:** latency down-counter with load/done and `busy` generation. Everything else is the single-FSM top.

## Test plan
The bench responder model returns `XO = {4'h6, XI_PRdSubA}` with a 5-stage pipeline.
1. **Write frame:** `rx_start`, header 0x03, data 0x15, 0x3F, `rx_stop`. Required: two `XI_PWr` pulses in consecutive cycles with `XI_PRWA`=3 and `XI_PD`=0x15 then 0x3F. No `XI_PRdFinished`.
2. **Read frame (autoinc on):** header 0x80, three `tx_req`. Required: `tx_data` 0x60, 0x61, 0x62, each 6 cycles after its `tx_req`. `rx_stop` then gives one `XI_PRdFinished` pulse.
3. **Wrap:** 17 reads. Required: the 17th returns 0x60 (sub-address 15 wraps to 0).
4. **`tx_req` during `RD_WAIT` and `rx_stop` during `RD_WAIT`:** Required: one `tx_valid` only, then `XI_PRdFinished` on the next cycle.
5. **`rx_start` mid-read:** Required: `XI_PRdFinished` pulses, the new header is accepted, and `XI_PRdSubA` is 0.
6. **`sys_rst` for 1 cycle in `RD_WAIT`:** Required: all outputs 0 next cycle, no `tx_valid`. Repeat scenario 2 with `PIF_XI_RD_AUTOINC_EN` undefined: all reads return 0x60.

Source files
------------

// File: rtl/pif_xi_init_pkg.sv
// Shared widths, header layout and FSM encoding for the XI bus initiator.
package pif_xi_init_pkg;

    localparam int unsigned TXA           = 4;
    localparam int unsigned TXSubA        = 4;
    localparam int unsigned TXD           = 6;
    localparam int unsigned I2C_DATA_BITS = 8;
    localparam int unsigned XO_W          = 8;
    localparam int unsigned HDR_RW_BIT    = 7;
    localparam int unsigned DEF_RD_LAT    = 5;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_WR      = 3'd2;
    localparam logic [2:0] ST_RD      = 3'd3;
    localparam logic [2:0] ST_RD_WAIT = 3'd4;

endpackage

// File: rtl/pif_xi_init_if.sv
// Link-side byte stream plus XI register bus seen by the initiator.
interface pif_xi_init_if
    import pif_xi_init_pkg::*;
#(
    parameter int unsigned A_W    = TXA,
    parameter int unsigned SUBA_W = TXSubA,
    parameter int unsigned DATA_W = TXD
);

    logic                     rx_start;
    logic                     rx_valid;
    logic [I2C_DATA_BITS-1:0] rx_data;
    logic                     rx_stop;
    logic                     tx_req;
    logic                     tx_valid;
    logic [XO_W-1:0]          tx_data;
    logic                     busy;
    logic                     XI_PWr;
    logic [A_W-1:0]           XI_PRWA;
    logic                     XI_PRdFinished;
    logic [SUBA_W-1:0]        XI_PRdSubA;
    logic [DATA_W-1:0]        XI_PD;
    logic [XO_W-1:0]          XO;

    modport master (
        input  rx_start, rx_valid, rx_data, rx_stop, tx_req, XO,
        output tx_valid, tx_data, busy, XI_PWr, XI_PRWA, XI_PRdFinished,
               XI_PRdSubA, XI_PD
    );

    modport slave (
        output rx_start, rx_valid, rx_data, rx_stop, tx_req, XO,
        input  tx_valid, tx_data, busy, XI_PWr, XI_PRWA, XI_PRdFinished,
               XI_PRdSubA, XI_PD
    );

endinterface

// File: rtl/pif_xi_init_rdwait.sv
// Readback latency down-counter: load starts a sample, done fires as the count reaches 0.
module pif_xi_rdwait
    import pif_xi_init_pkg::*;
#(
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_abort,
    output logic o_busy,
    output logic o_done_c
);

    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    // Done on the last decrement so the sample lands RD_LAT+1 cycles after the request.
    assign o_done_c = r_busy && (r_cnt == CNT_W'(1));
    assign o_busy   = r_busy;

    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= CNT_W'(RD_LAT);
            r_busy <= 1'b1;
        end else begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (o_done_c) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pif_xi_init.sv
// XI bus initiator: framed link bytes -> XI writes/reads, XO samples -> readback bytes.
// Optional: define PIF_XI_RD_AUTOINC_EN to advance XI_PRdSubA after every sample.
module pif_xi_init
    import pif_xi_init_pkg::*;
#(
    parameter int unsigned A_W    = TXA,
    parameter int unsigned SUBA_W = TXSubA,
    parameter int unsigned DATA_W = TXD,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic          xclk,
    input  logic          sys_rst,
    pif_xi_init_if.master bus
);

    logic [2:0]        r_state;
    logic              r_pwr;
    logic [A_W-1:0]    r_prwa;
    logic              r_fin;
    logic [SUBA_W-1:0] r_suba;
    logic [DATA_W-1:0] r_pd;
    logic              r_txv;
    logic [XO_W-1:0]   r_txd;
    logic              r_pend;

    logic [2:0]        w_state_nxt;
    logic              w_pwr_nxt;
    logic [A_W-1:0]    w_prwa_nxt;
    logic              w_fin_nxt;
    logic [SUBA_W-1:0] w_suba_nxt;
    logic [DATA_W-1:0] w_pd_nxt;
    logic              w_txv_nxt;
    logic [XO_W-1:0]   w_txd_nxt;
    logic              w_pend_nxt;
    logic              w_load;
    logic              w_abort;
    logic              w_busy;
    logic              w_done;
    logic [SUBA_W-1:0] w_suba_inc;
    logic              w_unused_rx;

`ifdef PIF_XI_RD_AUTOINC_EN
    assign w_suba_inc = r_suba + SUBA_W'(1);
`else
    assign w_suba_inc = '0;
`endif

    // Header bits that do not map onto address or data are intentionally dropped.
    assign w_unused_rx = &{1'b0, bus.rx_data};

    pif_xi_rdwait #(
        .RD_LAT (RD_LAT)
    ) u_rdwait (
        .clk      (xclk),
        .rst      (sys_rst),
        .i_load   (w_load),
        .i_abort  (w_abort),
        .o_busy   (w_busy),
        .o_done_c (w_done)
    );

    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pwr_nxt   = 1'b0;
        w_fin_nxt   = 1'b0;
        w_txv_nxt   = 1'b0;
        w_txd_nxt   = r_txd;
        w_prwa_nxt  = r_prwa;
        w_suba_nxt  = r_suba;
        w_pd_nxt    = r_pd;
        w_pend_nxt  = r_pend;
        w_load      = 1'b0;
        w_abort     = 1'b0;
        // A new frame start always wins; an interrupted read still reports completion.
        if (bus.rx_start) begin
            w_state_nxt = ST_HDR;
            w_pend_nxt  = 1'b0;
            w_abort     = 1'b1;
            w_fin_nxt   = (r_state == ST_RD) || (r_state == ST_RD_WAIT);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_HDR: begin
                    if (bus.rx_stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (bus.rx_valid) begin
                        w_prwa_nxt  = bus.rx_data[A_W-1:0];
                        w_suba_nxt  = '0;
                        w_state_nxt = bus.rx_data[HDR_RW_BIT] ? ST_RD : ST_WR;
                    end
                end
                ST_WR: begin
                    if (bus.rx_valid) begin
                        w_pd_nxt  = bus.rx_data[DATA_W-1:0];
                        w_pwr_nxt = 1'b1;
                    end
                    if (bus.rx_stop) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (r_pend || bus.rx_stop) begin
                        w_fin_nxt   = 1'b1;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else if (bus.tx_req) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    // A stop here is deferred until the pending sample has been returned.
                    if (bus.rx_stop) begin
                        w_pend_nxt = 1'b1;
                    end
                    if (w_done) begin
                        w_txd_nxt   = bus.XO;
                        w_txv_nxt   = 1'b1;
                        w_suba_nxt  = w_suba_inc;
                        w_state_nxt = ST_RD;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            r_pwr  <= 1'b0;
            r_prwa <= '0;
            r_fin  <= 1'b0;
            r_suba <= '0;
            r_pd   <= '0;
            r_txv  <= 1'b0;
            r_txd  <= '0;
            r_pend <= 1'b0;
        end else begin
            r_pwr  <= w_pwr_nxt;
            r_prwa <= w_prwa_nxt;
            r_fin  <= w_fin_nxt;
            r_suba <= w_suba_nxt;
            r_pd   <= w_pd_nxt;
            r_txv  <= w_txv_nxt;
            r_txd  <= w_txd_nxt;
            r_pend <= w_pend_nxt;
        end
    end

    assign bus.XI_PWr         = r_pwr;
    assign bus.XI_PRWA        = r_prwa;
    assign bus.XI_PRdFinished = r_fin;
    assign bus.XI_PRdSubA     = r_suba;
    assign bus.XI_PD          = r_pd;
    assign bus.tx_valid       = r_txv;
    assign bus.tx_data        = r_txd;
    assign bus.busy           = w_busy;

endmodule

// File: tb/tb_pif_xi_init.sv
// Scoreboard bench for pif_xi_init with a 5-stage XO responder model.
module tb_pif_xi_init;
    import pif_xi_init_pkg::*;

    typedef struct {
        logic [31:0] val;
        logic [31:0] addr;
        int unsigned due;
    } exp_t;

    logic        xclk = 1'b0;
    logic        sys_rst;
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    exp_t        wq[$];
    exp_t        rq[$];
    int unsigned fq[$];
    exp_t        mon_e;
    int unsigned mon_d;

    logic [3:0]  exp_suba;
    logic [3:0]  cur_addr;
    logic [7:0]  pipe [5];

    pif_xi_init_if bus ();

    pif_xi_init u_dut (
        .xclk    (xclk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 xclk = ~xclk;
    always @(posedge xclk) cyc <= cyc + 1;

    // Responder: XO follows the sub-address through five register stages.
    always @(posedge xclk) begin
        pipe[0] <= {4'h6, bus.XI_PRdSubA};
        for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.XO = pipe[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every output pulse must match the head of its queue, on the cycle it was due.
    always @(negedge xclk) begin
        if (bus.XI_PWr === 1'b1) begin
            chk("pwr_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                mon_e = wq.pop_front();
                chk("pwr_cycle", cyc, mon_e.due);
                chk("XI_PD", 32'(bus.XI_PD), mon_e.val);
                chk("XI_PRWA", 32'(bus.XI_PRWA), mon_e.addr);
            end
        end
        if (bus.tx_valid === 1'b1) begin
            chk("txv_expected", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) begin
                mon_e = rq.pop_front();
                chk("txv_cycle", cyc, mon_e.due);
                chk("tx_data", 32'(bus.tx_data), mon_e.val);
            end
        end
        if (bus.XI_PRdFinished === 1'b1) begin
            chk("fin_expected", 32'(fq.size() != 0), 32'd1);
            if (fq.size() != 0) begin
                mon_d = fq.pop_front();
                chk("fin_cycle", cyc, mon_d);
            end
        end
    end

    task automatic tick();
        @(posedge xclk);
        #1;
    endtask

    task automatic adv_suba();
`ifdef PIF_XI_RD_AUTOINC_EN
        exp_suba = exp_suba + 4'd1;
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_txv"},  32'(bus.tx_valid), 32'd0);
        chk({tag, "_txd"},  32'(bus.tx_data), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_pwr"},  32'(bus.XI_PWr), 32'd0);
        chk({tag, "_prwa"}, 32'(bus.XI_PRWA), 32'd0);
        chk({tag, "_fin"},  32'(bus.XI_PRdFinished), 32'd0);
        chk({tag, "_suba"}, 32'(bus.XI_PRdSubA), 32'd0);
        chk({tag, "_pd"},   32'(bus.XI_PD), 32'd0);
    endtask

    task automatic start_frame(input logic [7:0] hdr, input logic in_read);
        if (in_read) fq.push_back(cyc + 1);
        bus.rx_start = 1'b1;
        tick();
        bus.rx_start = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = hdr;
        tick();
        bus.rx_valid = 1'b0;
        cur_addr = hdr[3:0];
        exp_suba = 4'd0;
    endtask

    task automatic wr_byte(input logic [7:0] d);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        wq.push_back('{32'(d[5:0]), 32'(cur_addr), cyc + 1});
        tick();
    endtask

    task automatic stop_frame(input logic in_read);
        if (in_read) fq.push_back(cyc + 1);
        bus.rx_stop = 1'b1;
        tick();
        bus.rx_stop = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (wq.size() + rq.size() + fq.size()) != 0; k++) tick();
        chk("wq_left", 32'(wq.size()), 32'd0);
        chk("rq_left", 32'(rq.size()), 32'd0);
        chk("fq_left", 32'(fq.size()), 32'd0);
        wq.delete();
        rq.delete();
        fq.delete();
    endtask

    task automatic rd_sample();
        rq.push_back('{32'({4'h6, exp_suba}), 32'd0, cyc + 6});
        bus.tx_req = 1'b1;
        tick();
        bus.tx_req = 1'b0;
        chk("busy_set", 32'(bus.busy), 32'd1);
        for (int k = 0; k < 20 && rq.size() != 0; k++) tick();
        if (rq.size() != 0) begin
            chk("rd_timeout", 32'(rq.size()), 32'd0);
            rq.delete();
        end
        chk("busy_clr", 32'(bus.busy), 32'd0);
        adv_suba();
        chk("suba", 32'(bus.XI_PRdSubA), 32'(exp_suba));
    endtask

    initial begin
        int unsigned due;
        sys_rst      = 1'b1;
        bus.rx_start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_stop  = 1'b0;
        bus.tx_req   = 1'b0;
        exp_suba     = 4'd0;
        cur_addr     = 4'd0;
        repeat (3) tick();
        check_all_zero("reset");
        sys_rst = 1'b0;
        tick();

        // Write frame: back-to-back data, then truncation and stop-with-data.
        start_frame(8'h03, 1'b0);
        wr_byte(8'h15);
        wr_byte(8'h3F);
        bus.rx_valid = 1'b0;
        stop_frame(1'b0);
        drain();
        start_frame(8'h0A, 1'b0);
        wr_byte(8'hFF);
        bus.rx_stop = 1'b1;
        wr_byte(8'h2A);
        bus.rx_stop  = 1'b0;
        bus.rx_valid = 1'b0;
        tick();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h11;
        tick();
        bus.rx_valid = 1'b0;
        drain();

        // Read frame with three samples.
        start_frame(8'h80, 1'b0);
        chk("rd_prwa", 32'(bus.XI_PRWA), 32'd0);
        repeat (3) rd_sample();
        stop_frame(1'b1);
        drain();

        // Sub-address wrap over 17 samples.
        start_frame(8'h82, 1'b0);
        repeat (17) rd_sample();
        stop_frame(1'b1);
        drain();

        // tx_req and rx_stop while a sample is pending.
        start_frame(8'h81, 1'b0);
        due = cyc + 6;
        rq.push_back('{32'({4'h6, exp_suba}), 32'd0, due});
        bus.tx_req = 1'b1;
        tick();
        bus.tx_req = 1'b1;
        tick();
        bus.tx_req  = 1'b0;
        bus.rx_stop = 1'b1;
        fq.push_back(due + 1);
        tick();
        bus.rx_stop = 1'b0;
        drain();

        // rx_start mid-read aborts and restarts at sub-address 0.
        start_frame(8'h83, 1'b0);
        rd_sample();
        start_frame(8'h84, 1'b1);
        chk("restart_prwa", 32'(bus.XI_PRWA), 32'd4);
        chk("restart_suba", 32'(bus.XI_PRdSubA), 32'd0);
        rd_sample();
        stop_frame(1'b1);
        drain();

        // Reset while a sample is in flight: everything clears, no late pulse.
        start_frame(8'h87, 1'b0);
        bus.tx_req = 1'b1;
        tick();
        bus.tx_req = 1'b0;
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check_all_zero("midrst");
        repeat (10) tick();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
